// File: rtl/bounce_counter_param.sv
// Up/down counter between MIN_VAL..MAX_VAL with wrap-up, wrap-down, bounce and hold modes.
// Registered count/dir, one edge per step; COUNTER_LOAD_EN adds a clamped synchronous load.
module bounce_counter_param #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
`ifdef COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             terminal
);

  localparam logic [1:0] UP_WRAP   = 2'b00;
  localparam logic [1:0] DOWN_WRAP = 2'b01;
  localparam logic [1:0] BOUNCE    = 2'b10;

  localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  if (WIDTH < 2 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 2**WIDTH-1) begin : g_bad_params
    $error("bounce_counter_param: need WIDTH>=2 and 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end

  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;

  // Bounce turns around at the limits without repeating the endpoint.
  always_comb begin
    step_count = count;
    step_dir   = dir;
    case (mode)
      UP_WRAP: begin
        step_count = (count == MAX_L) ? MIN_L : count + ONE;
        step_dir   = 1'b0;
      end
      DOWN_WRAP: begin
        step_count = (count == MIN_L) ? MAX_L : count - ONE;
        step_dir   = 1'b1;
      end
      BOUNCE: begin
        if (!dir) begin
          if (count == MAX_L) begin
            step_count = count - ONE;
            step_dir   = 1'b1;
          end else begin
            step_count = count + ONE;
          end
        end else begin
          if (count == MIN_L) begin
            step_count = count + ONE;
            step_dir   = 1'b0;
          end else begin
            step_count = count - ONE;
          end
        end
      end
      default: begin
        step_count = count;
        step_dir   = dir;
      end
    endcase
  end

`ifdef COUNTER_LOAD_EN
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = (load_value < MIN_L) ? MIN_L :
                        (load_value > MAX_L) ? MAX_L : load_value;
`endif

  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
`ifdef COUNTER_LOAD_EN
    if (load) begin
      count_nxt = load_clamped;
    end else if (enable) begin
      count_nxt = step_count;
      dir_nxt   = step_dir;
    end
`else
    if (enable) begin
      count_nxt = step_count;
      dir_nxt   = step_dir;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= MIN_L;
      dir   <= 1'b0;
    end else begin
      count <= count_nxt;
      dir   <= dir_nxt;
    end
  end

  assign terminal = dir ? (count == MIN_L) : (count == MAX_L);

endmodule

// File: tb/tb_bounce_counter_param.sv
// Directed bench: default 0..15 instance (u0) and a 3..9 instance (u1) sharing clock and reset.
module tb_bounce_counter_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       en0, en1;
  logic [1:0] mode0, mode1;
  logic [3:0] count0, count1;
  logic       dir0, dir1, term0, term1;
`ifdef COUNTER_LOAD_EN
  logic       load0, load1;
  logic [3:0] lv0, lv1;
`endif

  int total = 0;
  int bad   = 0;
  int exp_up[8]   = '{4, 5, 6, 7, 8, 9, 3, 4};
  int exp_down[3] = '{3, 9, 8};

  always #5 clock = ~clock;

  bounce_counter_param u0 (
    .clock(clock), .reset(reset), .enable(en0), .mode(mode0),
`ifdef COUNTER_LOAD_EN
    .load(load0), .load_value(lv0),
`endif
    .count(count0), .dir(dir0), .terminal(term0)
  );

  bounce_counter_param #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(9)) u1 (
    .clock(clock), .reset(reset), .enable(en1), .mode(mode1),
`ifdef COUNTER_LOAD_EN
    .load(load1), .load_value(lv1),
`endif
    .count(count1), .dir(dir1), .terminal(term1)
  );

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    mode0 = 2'b10; mode1 = 2'b00;
`ifdef COUNTER_LOAD_EN
    load0 = 1'b0; load1 = 1'b0; lv0 = 4'd0; lv1 = 4'd0;
`endif
    #2;
    check("rst_count0", int'(count0), 0);
    check("rst_dir0",   int'(dir0),   0);
    check("rst_term0",  int'(term0),  0);
    check("rst_count1", int'(count1), 3);
    check("rst_term1",  int'(term1),  0);
    #10 reset = 1'b0;

    // Triangle 0..15..0 over 40 enabled edges
    en0 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      int p;
      tick();
      p = k % 30;
      check($sformatf("bnc_count%0d", k), int'(count0), (p <= 15) ? p : 30 - p);
      check($sformatf("bnc_dir%0d", k),   int'(dir0),   (p >= 16 || p == 0) ? 1 : 0);
      check($sformatf("bnc_term%0d", k),  int'(term0),  (p == 15 || p == 0) ? 1 : 0);
    end
    en0 = 1'b0;

    // Wrap up then wrap down on 3..9
    en1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("up_count%0d", k), int'(count1), exp_up[k]);
      check($sformatf("up_term%0d", k),  int'(term1),  (exp_up[k] == 9) ? 1 : 0);
    end
    check("up_dir", int'(dir1), 0);
    mode1 = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("dn_count%0d", k), int'(count1), exp_down[k]);
      check($sformatf("dn_dir%0d", k),   int'(dir1),   1);
      check($sformatf("dn_term%0d", k),  int'(term1),  (k == 0) ? 1 : 0);
    end

    // Bounce keeps dir=1 from 8; enable toggles so only every other edge steps
    mode1 = 2'b10;
    for (int k = 0; k < 6; k++) begin
      en1 = (k % 2 == 0);
      tick();
      check($sformatf("tog_count%0d", k), int'(count1), 7 - k / 2);
    end
    check("tog_dir", int'(dir1), 1);
    mode1 = 2'b11;
    en1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold_count%0d", k), int'(count1), 5);
    end
    check("hold_dir", int'(dir1), 1);
    en1 = 1'b0;

`ifdef COUNTER_LOAD_EN
    load1 = 1'b1; lv1 = 4'd12;
    tick();
    check("ld_hi", int'(count1), 9);
    lv1 = 4'd1;
    tick();
    check("ld_lo", int'(count1), 3);
    lv1 = 4'd6; en1 = 1'b1; mode1 = 2'b10;
    tick();
    check("ld_en_count", int'(count1), 6);
    check("ld_en_dir",   int'(dir1),   1);
    load1 = 1'b0; en1 = 1'b0;
    tick();
    check("ld_release", int'(count1), 6);
`endif

    // u0 at 10 going up: 5 edges to 15, 8 more down to 7
    en0 = 1'b1;
    repeat (13) tick();
    en0 = 1'b0;
    check("pre_rst_count", int'(count0), 7);
    check("pre_rst_dir",   int'(dir0),   1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_count", int'(count0), 0);
    check("async_rst_dir",   int'(dir0),   0);
    check("async_rst_term",  int'(term0),  0);
    check("async_rst_count1", int'(count1), 3);
    #1 reset = 1'b0;
    en0 = 1'b1;
    tick();
    check("post_rst_count", int'(count0), 1);
    check("post_rst_dir",   int'(dir0),   0);
    en0 = 1'b0;

    // Bounce u1 to MAX, then switch to wrap-up on the stepping edge
    mode1 = 2'b10; en1 = 1'b1;
    repeat (6) tick();
    check("max_count", int'(count1), 9);
    check("max_dir",   int'(dir1),   0);
    check("max_term",  int'(term1),  1);
    mode1 = 2'b00;
    tick();
    check("sw_count", int'(count1), 3);
    check("sw_dir",   int'(dir1),   0);
    check("sw_term",  int'(term1),  0);
    en1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
